// File: rtl/muxn_pkg.sv
// Shared definitions for the parametrised multiplexer family.
package muxn_pkg;

  // Selection policy of an arbitrating mux.
  typedef enum logic {
    MODE_SEL = 1'b0,  // external select picks the source
    MODE_RR  = 1'b1   // round-robin among requesting inputs
  } mux_mode_e;

  // Defaults shared by the parametrised muxes.
  localparam int MUXN_WIDTH = 64;
  localparam int MUXN_N     = 4;

endpackage

// File: rtl/mux_arb_n_if.sv
// Handshake bundle of the N-input arbitrating mux: N producers in, one consumer out.
interface mux_arb_n_if
  import muxn_pkg::*;
#(
  parameter int WIDTH = MUXN_WIDTH,
  parameter int N     = MUXN_N,
  parameter int SELW  = $clog2(N)
);

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  mux_mode_e          mode;
  logic [SELW-1:0]    sel;
  logic [WIDTH-1:0]   out;
  logic               out_valid;
  logic               out_ready;
  logic [SELW-1:0]    out_src;

  // Environment side: producers, mode/select control and the consumer.
  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out, out_valid, out_src
  );

  // Mux side.
  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out, out_valid, out_src
  );

endinterface

// File: rtl/mux2_1.sv
// Two-input word multiplexer cell; s=0 selects a, s=1 selects b.
module mux2_1 #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  // Plain 2:1 steering.
  assign y = s ? b : a;

endmodule

// File: rtl/mux_arb_n_tree.sv
// SELW-level binary tree of mux2_1 cells selecting one of N words.
// Nodes are kept heap-ordered: node k has children 2k+1 and 2k+2, leaves
// sit at N-1+i, and a node at depth d steers with select bit SELW-1-d, so
// the path from the root follows the select bits MSB first.
module mux_arb_n_tree #(
  parameter int WIDTH = 64,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   y
);

  logic [WIDTH-1:0] node [2*N-1];

  generate
    // Leaves: the flattened input words.
    for (genvar gi = 0; gi < N; gi++) begin : g_leaf
      assign node[N-1+gi] = in_data[gi*WIDTH +: WIDTH];
    end

    // Internal nodes, one mux2_1 each.
    for (genvar gi = 0; gi < N - 1; gi++) begin : g_node
      localparam int DEPTH = $clog2(gi + 2) - 1;
      mux2_1 #(.WIDTH(WIDTH)) u_mux (
        .a (node[2*gi+1]),
        .b (node[2*gi+2]),
        .s (sel[SELW-1-DEPTH]),
        .y (node[gi])
      );
    end
  endgenerate

  assign y = node[0];

endmodule

// File: rtl/rr_grant.sv
// Round-robin grant: first requester after ptr, wrapping through ptr itself last.
module rr_grant #(
  parameter int N    = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] grant,
  output logic            grant_valid
);

  // Search origin; SELW-bit arithmetic wraps modulo N because N is a power of two.
  logic [SELW-1:0] base;
  logic [N-1:0]    rot;
  logic [SELW-1:0] offs;

  assign base = ptr + SELW'(1);

  // Rotate requests so bit 0 is the highest-priority input (ptr+1).
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
      assign rot[gi] = req[base + SELW'(gi)];
    end
  endgenerate

  // Lowest set bit of the rotated vector, then rotate the index back.
  always_comb begin
    offs        = '0;
    grant_valid = |rot;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) offs = SELW'(j);
    end
    grant = base + offs;
  end

endmodule

// File: rtl/mux_arb_n.sv
// N-input arbitrating mux with a one-entry registered output and valid/ready
// on every port. Holds only the output/pointer registers and the handshake.
module mux_arb_n
  import muxn_pkg::*;
#(
  parameter int WIDTH = MUXN_WIDTH,
  parameter int N     = MUXN_N,
  parameter int SELW  = $clog2(N)
) (
  input  logic        clk,
  input  logic        reset,
  mux_arb_n_if.slave  bus
);

  logic [WIDTH-1:0] out_reg;
  logic [SELW-1:0]  out_src_reg;
  logic             out_valid_reg;
  logic [SELW-1:0]  ptr_reg;

  logic             load_en;
  logic [SELW-1:0]  rr_idx;
  logic             rr_valid;
  logic [SELW-1:0]  grant;
  logic             grant_valid;
  logic             transfer;
  logic [N-1:0]     in_ready_w;
  logic [WIDTH-1:0] mux_y;

  // Output register is free when empty or being drained this cycle.
  assign load_en = !out_valid_reg || bus.out_ready;

  rr_grant #(.N(N), .SELW(SELW)) u_rr (
    .req         (bus.in_valid),
    .ptr         (ptr_reg),
    .grant       (rr_idx),
    .grant_valid (rr_valid)
  );

  // Grant source: external select (other requesters ignored) or round-robin.
  always_comb begin
    grant       = bus.sel;
    grant_valid = bus.in_valid[bus.sel];
    if (bus.mode == MODE_RR) begin
      grant       = rr_idx;
      grant_valid = rr_valid;
    end
  end

  // No input is accepted while reset is held.
  assign transfer = load_en && grant_valid && !reset;

  // One-hot accept towards the granted producer only.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ready
      assign in_ready_w[gi] = transfer && (grant == SELW'(gi));
    end
  endgenerate

  assign bus.in_ready = in_ready_w;

  mux_arb_n_tree #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) u_tree (
    .in_data (bus.in_data),
    .sel     (grant),
    .y       (mux_y)
  );

  // Output word, source tag and round-robin pointer; load wins over drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_reg       <= '0;
      out_src_reg   <= '0;
      out_valid_reg <= 1'b0;
      ptr_reg       <= SELW'(N - 1);
    end else if (transfer) begin
      out_reg       <= mux_y;
      out_src_reg   <= grant;
      out_valid_reg <= 1'b1;
      ptr_reg       <= grant;
    end else if (out_valid_reg && bus.out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign bus.out       = out_reg;
  assign bus.out_src   = out_src_reg;
  assign bus.out_valid = out_valid_reg;

endmodule
